// File: rtl/fifo_serializer.sv
// Purpose : pops bytes from an upstream FIFO and sends each one as a UART-style
//           frame: start(0), 8 data bits LSB first, optional even parity, stop(1).
// Latency : tx first goes low two cycles after the FETCH (read_en) cycle.
//           Each bit is held CLKS_PER_BIT cycles.
// Backpressure: tx_en low or empty_flag high holds off the next fetch. A frame
//           that has already started always completes; only reset aborts it.
// Ports   : clk, reset (async, active-low), tx_en, empty_flag, fifo_data[7:0] in;
//           read_en, tx, busy, frame_done out.
// Config  : define FIFO_SERIALIZER_PARITY_EN to add an even-parity bit (11-bit frame).
//           Without it the frame is 10 bits.
module fifo_serializer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       empty_flag,
  input  logic [7:0] fifo_data,
  output logic       read_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned   BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef FIFO_SERIALIZER_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            tx_q;
  logic            frame_done_q;
`ifdef FIFO_SERIALIZER_PARITY_EN
  logic            parity_q;
`endif

  // High in the last cycle of every bit period.
  logic baud_zero;
  assign baud_zero = (baud_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      tx_q         <= 1'b1;
      frame_done_q <= 1'b0;
`ifdef FIFO_SERIALIZER_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (tx_en && !empty_flag) state_q <= S_FETCH;
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          // FIFO read data is valid this cycle, one cycle after the pop.
          shreg_q <= fifo_data;
`ifdef FIFO_SERIALIZER_PARITY_EN
          parity_q <= ^fifo_data;
`endif
          tx_q    <= 1'b0;
          baud_q  <= BAUD_LAST;
          state_q <= S_START;
        end
        S_START: begin
          if (baud_zero) begin
            tx_q    <= shreg_q[0];
            baud_q  <= BAUD_LAST;
            bit_q   <= '0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_zero) begin
            baud_q  <= BAUD_LAST;
            shreg_q <= {1'b0, shreg_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
              tx_q    <= parity_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              // Next bit is the one that lands in bit 0 after this shift.
              tx_q <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`ifdef FIFO_SERIALIZER_PARITY_EN
        S_PARITY: begin
          if (baud_zero) begin
            tx_q    <= 1'b1;
            baud_q  <= BAUD_LAST;
            state_q <= S_STOP;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
`endif
        S_STOP: begin
          tx_q <= 1'b1;
          if (baud_zero) begin
            // Back-to-back frames skip IDLE entirely.
            if (tx_en && !empty_flag) state_q <= S_FETCH;
            else                      state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q - 1'b1;
            // Registered pulse lands in the cycle where baud_q reaches zero.
            if (baud_q == BAUD_ONE) frame_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign read_en    = (state_q == S_FETCH);
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Purpose : self-checking bench for fifo_serializer with CLKS_PER_BIT=4, fed by
//           a queue-like upstream FIFO model; expected tx waveform is built per
//           byte as a frame bit vector. Honors FIFO_SERIALIZER_PARITY_EN.
// Ports   : drives clk, reset, tx_en, empty_flag, fifo_data; observes the rest.
module tb_fifo_serializer;

  localparam int CPB = 4;
`ifdef FIFO_SERIALIZER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       reset;
  logic       tx_en;
  logic       empty_flag;
  logic [7:0] fifo_data;
  logic       read_en;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  // Upstream FIFO model: registered read data, empty when counts match.
  logic [7:0] mem [0:255];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int pop_err = 0;

  assign empty_flag = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (read_en) begin
      if (wr_cnt == rd_cnt) pop_err++;
      fifo_data <= mem[rd_cnt % 256];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  fifo_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_en      (tx_en),
    .empty_flag (empty_flag),
    .fifo_data  (fifo_data),
    .read_en    (read_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_cnt % 256] = b;
    wr_cnt = wr_cnt + 1;
  endtask

  // {read_en, tx, busy} must read idle for n cycles.
  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, 32'({read_en, tx, busy}), 32'(3'b010));
    end
  endtask

  // Waits up to max_wait cycles for the FETCH cycle, then checks the whole frame
  // cycle by cycle. Optionally drops tx_en during data bit 3.
  task automatic expect_frame(input logic [7:0] b, input int max_wait,
                              input bit drop, input string tag);
    logic [10:0] fr;
    bit          seen;
    logic        last;
    seen = 1'b0;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (read_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_fetch"}, 32'(seen), 32'(1));
    if (!seen) return;
    chk({tag, "_fetch_tx"}, 32'({tx, busy}), 32'(2'b11));
    @(negedge clk);
    chk({tag, "_load"}, 32'({read_en, tx, busy}), 32'(3'b011));
`ifdef FIFO_SERIALIZER_PARITY_EN
    fr = {1'b1, ^b, b, 1'b0};
`else
    fr = {2'b11, b, 1'b0};
`endif
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (drop && k == 4 && c == 0) tx_en = 1'b0;
        last = (k == NB - 1) && (c == CPB - 1);
        chk({tag, "_bit"}, 32'({tx, frame_done, busy, read_en}),
            32'({fr[k], last, 1'b1, 1'b0}));
      end
    end
  endtask

  initial begin
    logic [7:0] b1, b2, rb;
    reset = 1'b0;
    tx_en = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_out", 32'({tx, busy, read_en, frame_done}), 32'(4'b1000));
    reset = 1'b1;

    // Empty FIFO with tx_en high: nothing happens.
    tx_en = 1'b1;
    idle_cycles(100, "empty_hold");
    chk("empty_no_pop", 32'(rd_cnt), 32'(0));

    // Single byte 0xA5.
    push(8'hA5);
    expect_frame(8'hA5, 3, 1'b0, "a5");
    idle_cycles(3, "a5_idle");
    chk("a5_pops", 32'(rd_cnt), 32'(1));

    // Three bytes back-to-back: only FETCH+LOAD between frames.
    push(8'h11); push(8'h22); push(8'h33);
    expect_frame(8'h11, 3, 1'b0, "b2b_11");
    expect_frame(8'h22, 1, 1'b0, "b2b_22");
    expect_frame(8'h33, 1, 1'b0, "b2b_33");
    idle_cycles(3, "b2b_idle");

    // Parity-1 byte.
    push(8'h01);
    expect_frame(8'h01, 3, 1'b0, "x01");
    idle_cycles(2, "x01_idle");

    // Random back-to-back bytes.
    for (int i = 0; i < 8; i++) push(8'($urandom));
    for (int i = 0; i < 8; i++) begin
      rb = mem[(wr_cnt - 8 + i) % 256];
      expect_frame(rb, (i == 0) ? 3 : 1, 1'b0, "rand");
    end
    idle_cycles(2, "rand_idle");

    // tx_en dropped mid-frame: frame completes, next fetch waits for tx_en.
    b1 = 8'($urandom); b2 = 8'($urandom);
    push(b1); push(b2);
    expect_frame(b1, 3, 1'b1, "drop_b1");
    idle_cycles(20, "drop_hold");
    tx_en = 1'b1;
    expect_frame(b2, 3, 1'b0, "drop_b2");
    idle_cycles(2, "drop_idle");

    // Reset during data bit 3 aborts at once; next byte goes out intact.
    b1 = 8'($urandom) | 8'h01; b2 = 8'($urandom);
    push(b1); push(b2);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (read_en) begin
          seen = 1'b1;
          break;
        end
      end
      chk("rst_fetch", 32'(seen), 32'(1));
    end
    repeat (1 + CPB + 3 * CPB + 2) @(negedge clk);
    chk("rst_pre_bit3", 32'({tx, busy}), 32'({b1[3], 1'b1}));
    reset = 1'b0;
    #1;
    chk("rst_async", 32'({tx, busy, read_en, frame_done}), 32'(4'b1000));
    repeat (3) @(negedge clk);
    chk("rst_held", 32'({tx, busy, read_en, frame_done}), 32'(4'b1000));
    reset = 1'b1;
    expect_frame(b2, 3, 1'b0, "rst_next");
    idle_cycles(3, "rst_idle");

    chk("all_popped", 32'(rd_cnt), 32'(wr_cnt));
    chk("no_empty_pop", 32'(pop_err), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
